// File: rtl/cam_checker_pkg.sv
// Shared types for the CAM reference model: index/age widths, model entries and
// the expected-read record carried to the response cycle.
package cam_checker_pkg;

    localparam int CAM_SIZE  = 8;
    localparam int CAM_KEY_W = 16;
    localparam int CAM_VAL_W = 16;
    localparam int IDX_W     = (CAM_SIZE > 1) ? $clog2(CAM_SIZE) : 1;

    typedef logic [IDX_W-1:0] age_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   thresh_t;

    typedef struct packed {
        logic                 valid;
        logic [CAM_KEY_W-1:0] key;
        logic [CAM_VAL_W-1:0] val;
        age_t                 age;
    } entry_t;

    typedef struct packed {
        logic                 valid;
        logic                 hit;
        logic [CAM_VAL_W-1:0] val;
    } exp_t;

endpackage

// File: rtl/cam_err_window.sv
// Scores an external error pulse stream against the checker's own mismatch stream
// inside a +/-RADIUS cycle window, with saturating false-positive/negative counters.
module cam_err_window
    import cam_checker_pkg::*;
#(
    parameter int RADIUS = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mismatch_i,
    input  logic             ext_err_i,
    output logic [CNT_W-1:0] false_pos_o,
    output logic [CNT_W-1:0] false_neg_o
);

    localparam int WIN = 2*RADIUS + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIN-1:0]   mis_win_s;
    logic [WIN-1:0]   err_win_s;
    logic             fp_ev_s;
    logic             fn_ev_s;
    logic [CNT_W-1:0] fp_r;
    logic [CNT_W-1:0] fn_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    endfunction

    // Bit 0 of each window is the current cycle; bit RADIUS is the centre tap.
    generate
        if (RADIUS == 0) begin : g_nohist
            assign mis_win_s = mismatch_i;
            assign err_win_s = ext_err_i;
        end else begin : g_hist
            logic [2*RADIUS-1:0] mis_hist_r;
            logic [2*RADIUS-1:0] err_hist_r;

            // Shift the last 2*RADIUS cycles of both event streams
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mis_hist_r <= '0;
                    err_hist_r <= '0;
                end else begin
                    mis_hist_r <= {mis_hist_r[2*RADIUS-2:0], mismatch_i};
                    err_hist_r <= {err_hist_r[2*RADIUS-2:0], ext_err_i};
                end
            end

            assign mis_win_s = {mis_hist_r, mismatch_i};
            assign err_win_s = {err_hist_r, ext_err_i};
        end
    endgenerate

    assign fn_ev_s = mis_win_s[RADIUS] && !(|err_win_s);
    assign fp_ev_s = err_win_s[RADIUS] && !(|mis_win_s);

    // Saturating scoring counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_r <= '0;
            fn_r <= '0;
        end else begin
            if (fp_ev_s) fp_r <= sat_inc(fp_r);
            if (fn_ev_s) fn_r <= sat_inc(fn_r);
        end
    end

    assign false_pos_o = fp_r;
    assign false_neg_o = fn_r;

endmodule

// File: rtl/cam_checker.sv
// Reference LRU model of the CAM that shadows the request bus, compares DUT read
// responses, collects hit/evict/adjacency coverage and scores an external error flag.
module cam_checker
    import cam_checker_pkg::*;
#(
    parameter int CAMSIZE = CAM_SIZE,
    parameter int KEY_W   = CAM_KEY_W,
    parameter int VAL_W   = CAM_VAL_W,
    parameter int RD_LAT  = 1,
    parameter int RADIUS  = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_i,
    input  logic               rw_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [VAL_W-1:0]   val_i,
    input  logic               rd_hit_i,
    input  logic [VAL_W-1:0]   rd_val_i,
    input  logic               ext_err_i,
    output logic               mismatch_o,
    output logic [CAMSIZE-1:0] evict_cov_o,
    output logic [CAMSIZE-1:0] hit_cov_o,
    output logic               ww_cov_o,
    output logic               wr_cov_o,
    output logic               cov_done_o,
    output logic [CNT_W-1:0]   false_pos_o,
    output logic [CNT_W-1:0]   false_neg_o
);

    entry_t             entries_r     [CAMSIZE];
    entry_t             entries_nxt_s [CAMSIZE];
    logic               hit_s;
    logic               free_s;
    idx_t               hit_idx_s;
    idx_t               free_idx_s;
    idx_t               victim_idx_s;
    idx_t               tgt_s;
    logic               fill_s;
    logic               evict_s;
    logic               touch_s;
    thresh_t            thresh_s;
    exp_t               cur_exp_s;
    exp_t               pop_exp_s;
    logic               mismatch_s;
    logic               ww_s;
    logic               wr_s;
    logic [CAMSIZE-1:0] evict_cov_r;
    logic [CAMSIZE-1:0] hit_cov_r;
    logic               ww_cov_r;
    logic               wr_cov_r;
    logic               cov_done_r;
    logic               prev_req_r;
    logic               prev_rw_r;
    logic [KEY_W-1:0]   prev_key_r;

    // Key match, lowest free slot and LRU victim, all on the current model state
    always_comb begin
        hit_s        = 1'b0;
        free_s       = 1'b0;
        hit_idx_s    = idx_t'(0);
        free_idx_s   = idx_t'(0);
        victim_idx_s = idx_t'(0);
        for (int i = CAMSIZE-1; i >= 0; i--) begin
            hit_s        = hit_s | (entries_r[i].valid && (entries_r[i].key == key_i));
            hit_idx_s    = hit_idx_s |
                           ((entries_r[i].valid && (entries_r[i].key == key_i)) ? idx_t'(i) : idx_t'(0));
            free_s       = free_s | !entries_r[i].valid;
            free_idx_s   = !entries_r[i].valid ? idx_t'(i) : free_idx_s;
            victim_idx_s = victim_idx_s |
                           ((entries_r[i].age == age_t'(CAMSIZE-1)) ? idx_t'(i) : idx_t'(0));
        end
    end

    // Next model state; a fill ages every valid entry, a hit or eviction only the younger ones
    always_comb begin
        entries_nxt_s = entries_r;
        fill_s   = req_i && rw_i && !hit_s && free_s;
        evict_s  = req_i && rw_i && !hit_s && !free_s;
        touch_s  = req_i && (hit_s || rw_i);
        tgt_s    = hit_s ? hit_idx_s : (free_s ? free_idx_s : victim_idx_s);
        thresh_s = fill_s ? thresh_t'(CAMSIZE) : {1'b0, entries_r[tgt_s].age};
        if (touch_s) begin
            for (int i = 0; i < CAMSIZE; i++) begin
                if (idx_t'(i) == tgt_s) begin
                    entries_nxt_s[i].valid = 1'b1;
                    entries_nxt_s[i].age   = age_t'(0);
                    entries_nxt_s[i].key   = rw_i ? key_i : entries_r[i].key;
                    entries_nxt_s[i].val   = rw_i ? val_i : entries_r[i].val;
                end else if (entries_r[i].valid && ({1'b0, entries_r[i].age} < thresh_s)) begin
                    entries_nxt_s[i].age = entries_r[i].age + age_t'(1);
                end else begin
                    entries_nxt_s[i] = entries_r[i];
                end
            end
        end else begin
            entries_nxt_s = entries_r;
        end
    end

    // Model state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CAMSIZE; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            entries_r <= entries_nxt_s;
        end
    end

    assign cur_exp_s = {req_i && !rw_i, hit_s, entries_r[hit_idx_s].val};

    generate
        if (RD_LAT == 0) begin : g_comb
            assign pop_exp_s = cur_exp_s;
        end else begin : g_pipe
            exp_t pipe_r [RD_LAT];

            // Carry the expected read result to the DUT response cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < RD_LAT; k++) begin
                        pipe_r[k] <= '0;
                    end
                end else begin
                    pipe_r[0] <= cur_exp_s;
                    for (int k = 1; k < RD_LAT; k++) begin
                        pipe_r[k] <= pipe_r[k-1];
                    end
                end
            end

            assign pop_exp_s = pipe_r[RD_LAT-1];
        end
    endgenerate

    // Read data is only meaningful when the model expects a hit.
    assign mismatch_s = pop_exp_s.valid &&
                        ((rd_hit_i != pop_exp_s.hit) || (pop_exp_s.hit && (rd_val_i != pop_exp_s.val)));
    assign mismatch_o = mismatch_s && rst_n;

    assign ww_s = prev_req_r && prev_rw_r && req_i && rw_i && (prev_key_r == key_i);
    assign wr_s = prev_req_r && prev_rw_r && req_i && !rw_i && (prev_key_r == key_i);

    // Sticky coverage bits and the previous request used for adjacency coverage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evict_cov_r <= '0;
            hit_cov_r   <= '0;
            ww_cov_r    <= 1'b0;
            wr_cov_r    <= 1'b0;
            cov_done_r  <= 1'b0;
            prev_req_r  <= 1'b0;
            prev_rw_r   <= 1'b0;
            prev_key_r  <= '0;
        end else begin
            if (req_i && hit_s) hit_cov_r[hit_idx_s] <= 1'b1;
            if (evict_s)        evict_cov_r[victim_idx_s] <= 1'b1;
            if (ww_s)           ww_cov_r <= 1'b1;
            if (wr_s)           wr_cov_r <= 1'b1;
            cov_done_r <= &{evict_cov_r, hit_cov_r, ww_cov_r, wr_cov_r};
            prev_req_r <= req_i;
            prev_rw_r  <= rw_i;
            prev_key_r <= key_i;
        end
    end

    assign evict_cov_o = evict_cov_r;
    assign hit_cov_o   = hit_cov_r;
    assign ww_cov_o    = ww_cov_r;
    assign wr_cov_o    = wr_cov_r;
    assign cov_done_o  = cov_done_r;

    cam_err_window #(
        .RADIUS (RADIUS),
        .CNT_W  (CNT_W)
    ) u_err_window (
        .clk         (clk),
        .rst_n       (rst_n),
        .mismatch_i  (mismatch_o),
        .ext_err_i   (ext_err_i),
        .false_pos_o (false_pos_o),
        .false_neg_o (false_neg_o)
    );

endmodule

// File: tb/tb_cam_checker.sv
// Self-checking bench for cam_checker: queue-based LRU reference model, directed
// scenarios from the feature list and a randomized read/write/error stream.
module tb_cam_checker;

    localparam int CAMSIZE = 8;
    localparam int KEY_W   = 16;
    localparam int VAL_W   = 16;
    localparam int RD_LAT  = 1;
    localparam int RADIUS  = 1;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_i, rw_i, rd_hit_i, ext_err_i;
    logic [KEY_W-1:0]   key_i;
    logic [VAL_W-1:0]   val_i, rd_val_i;
    logic               mismatch_o, ww_cov_o, wr_cov_o, cov_done_o;
    logic [CAMSIZE-1:0] evict_cov_o, hit_cov_o;
    logic [CNT_W-1:0]   false_pos_o, false_neg_o;

    cam_checker #(
        .CAMSIZE(CAMSIZE), .KEY_W(KEY_W), .VAL_W(VAL_W),
        .RD_LAT(RD_LAT), .RADIUS(RADIUS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .rw_i(rw_i), .key_i(key_i),
        .val_i(val_i), .rd_hit_i(rd_hit_i), .rd_val_i(rd_val_i), .ext_err_i(ext_err_i),
        .mismatch_o(mismatch_o), .evict_cov_o(evict_cov_o), .hit_cov_o(hit_cov_o),
        .ww_cov_o(ww_cov_o), .wr_cov_o(wr_cov_o), .cov_done_o(cov_done_o),
        .false_pos_o(false_pos_o), .false_neg_o(false_neg_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic             hit;
        logic [VAL_W-1:0] val;
    } rsp_t;

    // Reference model: slots plus an MRU-first queue of slot numbers.
    logic             m_valid [CAMSIZE];
    logic [KEY_W-1:0] m_key   [CAMSIZE];
    logic [VAL_W-1:0] m_val   [CAMSIZE];
    int               lru_q [$];
    rsp_t             rsp_q [$];
    logic             mis_h [$];
    logic             err_h [$];
    logic [CAMSIZE-1:0] m_hit_cov, m_evict_cov;
    logic             m_ww, m_wr, exp_done;
    logic             prev_req, prev_rw;
    logic [KEY_W-1:0] prev_key;
    int               exp_fp, exp_fn;

    int n_checks = 0;
    int n_pass   = 0;

    logic               obs_mis, obs_ww, obs_wr, obs_done;
    logic [CAMSIZE-1:0] obs_evict, obs_hit;
    logic [CNT_W-1:0]   obs_fp, obs_fn;

    task automatic model_reset();
        for (int i = 0; i < CAMSIZE; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_val[i]   = '0;
        end
        lru_q.delete();
        rsp_q.delete();
        mis_h.delete();
        err_h.delete();
        for (int i = 0; i < 2*RADIUS; i++) begin
            mis_h.push_back(1'b0);
            err_h.push_back(1'b0);
        end
        m_hit_cov = '0; m_evict_cov = '0;
        m_ww = 1'b0; m_wr = 1'b0; exp_done = 1'b0;
        prev_req = 1'b0; prev_rw = 1'b0; prev_key = '0;
        exp_fp = 0; exp_fn = 0;
    endtask

    function automatic int find_key(input logic [KEY_W-1:0] k);
        for (int i = 0; i < CAMSIZE; i++) begin
            if (m_valid[i] && (m_key[i] == k)) return i;
        end
        return -1;
    endfunction

    function automatic int find_free();
        for (int i = 0; i < CAMSIZE; i++) begin
            if (!m_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic touch(input int s);
        for (int j = 0; j < lru_q.size(); j++) begin
            if (lru_q[j] == s) begin
                lru_q.delete(j);
                break;
            end
        end
        lru_q.push_front(s);
    endtask

    // One bus cycle. mode 0: correct response, 1: corrupted response, 2: explicit x_hit/x_val.
    task automatic step(input logic req, input logic rw, input logic [KEY_W-1:0] key,
                        input logic [VAL_W-1:0] val, input int mode, input logic x_hit,
                        input logic [VAL_W-1:0] x_val, input logic err);
        rsp_t             cur, pop;
        int               h, f, v;
        logic             drv_hit, exp_mis, any_m, any_e;
        logic [VAL_W-1:0] drv_val;

        h = find_key(key);
        cur.v = req && !rw;
        cur.hit = (h >= 0);
        cur.val = '0;
        if (h >= 0) cur.val = m_val[h];
        rsp_q.push_back(cur);
        if (rsp_q.size() > RD_LAT) pop = rsp_q.pop_front();
        else pop = '0;

        drv_hit = 1'($urandom_range(0, 1));
        drv_val = VAL_W'($urandom);
        if (mode == 2) begin
            drv_hit = x_hit;
            drv_val = x_val;
        end else if (pop.v && mode == 1) begin
            if (pop.hit && $urandom_range(0, 1) == 1) begin
                drv_hit = 1'b1;
                drv_val = pop.val ^ (VAL_W'(1) << $urandom_range(0, VAL_W-1));
            end else begin
                drv_hit = !pop.hit;
            end
        end else if (pop.v) begin
            drv_hit = pop.hit;
            if (pop.hit) drv_val = pop.val;
        end
        exp_mis = pop.v && ((drv_hit != pop.hit) || (pop.hit && (drv_val != pop.val)));

        req_i = req; rw_i = rw; key_i = key; val_i = val;
        rd_hit_i = drv_hit; rd_val_i = drv_val; ext_err_i = err;

        @(negedge clk);
        obs_mis = mismatch_o; obs_evict = evict_cov_o; obs_hit = hit_cov_o;
        obs_ww = ww_cov_o; obs_wr = wr_cov_o; obs_done = cov_done_o;
        obs_fp = false_pos_o; obs_fn = false_neg_o;

        n_checks++;
        if (obs_mis !== exp_mis) $display("FAIL step_mismatch t=%0t got %b want %b", $time, obs_mis, exp_mis);
        else n_pass++;
        n_checks++;
        if (obs_evict !== m_evict_cov) $display("FAIL step_evict_cov t=%0t got %h want %h", $time, obs_evict, m_evict_cov);
        else n_pass++;
        n_checks++;
        if (obs_hit !== m_hit_cov) $display("FAIL step_hit_cov t=%0t got %h want %h", $time, obs_hit, m_hit_cov);
        else n_pass++;
        n_checks++;
        if (obs_ww !== m_ww) $display("FAIL step_ww_cov t=%0t got %b want %b", $time, obs_ww, m_ww);
        else n_pass++;
        n_checks++;
        if (obs_wr !== m_wr) $display("FAIL step_wr_cov t=%0t got %b want %b", $time, obs_wr, m_wr);
        else n_pass++;
        n_checks++;
        if (obs_done !== exp_done) $display("FAIL step_cov_done t=%0t got %b want %b", $time, obs_done, exp_done);
        else n_pass++;
        n_checks++;
        if (obs_fp !== CNT_W'(exp_fp)) $display("FAIL step_false_pos t=%0t got %0d want %0d", $time, obs_fp, exp_fp);
        else n_pass++;
        n_checks++;
        if (obs_fn !== CNT_W'(exp_fn)) $display("FAIL step_false_neg t=%0t got %0d want %0d", $time, obs_fn, exp_fn);
        else n_pass++;

        // Score the window whose centre is RADIUS cycles old.
        mis_h.push_back(exp_mis);
        err_h.push_back(err);
        any_m = 1'b0; any_e = 1'b0;
        for (int j = 0; j < mis_h.size(); j++) begin
            any_m = any_m | mis_h[j];
            any_e = any_e | err_h[j];
        end
        if (mis_h[RADIUS] && !any_e && exp_fn < CNT_MAX) exp_fn++;
        if (err_h[RADIUS] && !any_m && exp_fp < CNT_MAX) exp_fp++;
        void'(mis_h.pop_front());
        void'(err_h.pop_front());

        exp_done = (&m_hit_cov) && (&m_evict_cov) && m_ww && m_wr;
        if (prev_req && prev_rw && req && (prev_key == key)) begin
            if (rw) m_ww = 1'b1;
            else m_wr = 1'b1;
        end
        prev_req = req; prev_rw = rw; prev_key = key;

        if (req && h >= 0) begin
            touch(h);
            m_hit_cov[h] = 1'b1;
            if (rw) m_val[h] = val;
        end else if (req && rw) begin
            f = find_free();
            if (f >= 0) begin
                m_valid[f] = 1'b1; m_key[f] = key; m_val[f] = val;
                lru_q.push_front(f);
            end else begin
                v = lru_q.pop_back();
                m_evict_cov[v] = 1'b1;
                m_key[v] = key; m_val[v] = val;
                lru_q.push_front(v);
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr_key(input logic [KEY_W-1:0] k, input logic [VAL_W-1:0] d);
        step(1'b1, 1'b1, k, d, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd_key(input logic [KEY_W-1:0] k);
        step(1'b1, 1'b0, k, '0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_i = 1'b0; rw_i = 1'b0; key_i = '0; val_i = '0;
        rd_hit_i = 1'b1; rd_val_i = '0; ext_err_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mismatch_o, ww_cov_o, wr_cov_o, cov_done_o} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {mismatch_o, ww_cov_o, wr_cov_o, cov_done_o});
        else n_pass++;
        n_checks++;
        if ({evict_cov_o, hit_cov_o} !== 16'h0000) $display("FAIL reset_cov got %h want 0000", {evict_cov_o, hit_cov_o});
        else n_pass++;
        n_checks++;
        if ({false_pos_o, false_neg_o} !== 32'h0) $display("FAIL reset_cnt got %h want 0", {false_pos_o, false_neg_o});
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill_evict();
        for (int k = 0; k < 8; k++) wr_key(KEY_W'(k), VAL_W'(16'h1000 + k));
        wr_key(16'd8, 16'h1008);
        idle(1);
        n_checks++;
        if (obs_evict !== 8'h01) $display("FAIL fill_evict_first got %h want 01", obs_evict);
        else n_pass++;
        for (int k = 9; k < 16; k++) wr_key(KEY_W'(k), VAL_W'(16'h1000 + k));
        idle(1);
        n_checks++;
        if (obs_evict !== 8'hFF) $display("FAIL fill_evict_all got %h want ff", obs_evict);
        else n_pass++;
        n_checks++;
        if (obs_mis !== 1'b0) $display("FAIL fill_no_mismatch got %b want 0", obs_mis);
        else n_pass++;
    endtask

    task automatic test_write_read();
        wr_key(16'd5, 16'hABCD);
        rd_key(16'd5);
        step(1'b0, 1'b0, '0, '0, 2, 1'b1, 16'hABCD, 1'b0);
        n_checks++;
        if (obs_mis !== 1'b0) $display("FAIL wr_then_rd_mismatch got %b want 0", obs_mis);
        else n_pass++;
        n_checks++;
        if (obs_wr !== 1'b1) $display("FAIL wr_cov got %b want 1", obs_wr);
        else n_pass++;
    endtask

    task automatic test_absent_read();
        rd_key(16'd3);
        n_checks++;
        if (obs_mis !== 1'b0) $display("FAIL absent_req_cycle got %b want 0", obs_mis);
        else n_pass++;
        step(1'b0, 1'b0, '0, '0, 2, 1'b1, 16'h5A5A, 1'b0);
        n_checks++;
        if (obs_mis !== 1'b1) $display("FAIL absent_rsp_cycle got %b want 1", obs_mis);
        else n_pass++;
        idle(1);
        n_checks++;
        if (obs_mis !== 1'b0) $display("FAIL absent_after got %b want 0", obs_mis);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        wr_key(16'd7, 16'h1111);
        wr_key(16'd7, 16'h2222);
        rd_key(16'd7);
        step(1'b0, 1'b0, '0, '0, 2, 1'b1, 16'h2222, 1'b0);
        n_checks++;
        if (obs_mis !== 1'b0) $display("FAIL ww_second_value got %b want 0", obs_mis);
        else n_pass++;
        n_checks++;
        if (obs_ww !== 1'b1) $display("FAIL ww_cov got %b want 1", obs_ww);
        else n_pass++;
    endtask

    task automatic test_err_window();
        logic [CNT_W-1:0] fp0, fn0;
        idle(4);
        fp0 = obs_fp; fn0 = obs_fn;
        rd_key(16'd7);
        step(1'b0, 1'b0, '0, '0, 1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 0, 1'b0, '0, 1'b1);
        idle(4);
        n_checks++;
        if ({obs_fp - fp0, obs_fn - fn0} !== 32'h0)
            $display("FAIL err_near got fp+%0d fn+%0d want 0 0", obs_fp - fp0, obs_fn - fn0);
        else n_pass++;
        rd_key(16'd7);
        step(1'b0, 1'b0, '0, '0, 1, 1'b0, '0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, '0, '0, 0, 1'b0, '0, 1'b1);
        idle(4);
        n_checks++;
        if (obs_fp - fp0 !== CNT_W'(1)) $display("FAIL err_far_fp got %0d want 1", obs_fp - fp0);
        else n_pass++;
        n_checks++;
        if (obs_fn - fn0 !== CNT_W'(1)) $display("FAIL err_far_fn got %0d want 1", obs_fn - fn0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rd_key(16'd7);
        rst_n = 1'b0;
        rd_hit_i = 1'b0;
        #1;
        n_checks++;
        if ({mismatch_o, ww_cov_o, wr_cov_o, cov_done_o, evict_cov_o, hit_cov_o, false_pos_o, false_neg_o} !== 52'h0)
            $display("FAIL reset_mid_outputs got %h want 0",
                     {mismatch_o, ww_cov_o, wr_cov_o, cov_done_o, evict_cov_o, hit_cov_o, false_pos_o, false_neg_o});
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, '0, 2, 1'b1, 16'hFFFF, 1'b0);
            n_checks++;
            if (obs_mis !== 1'b0) $display("FAIL reset_mid_no_mismatch got %b want 0", obs_mis);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic rq, rw, er;
        int   md;
        for (int i = 0; i < 3000; i++) begin
            rq = ($urandom_range(0, 9) < 8);
            rw = 1'($urandom_range(0, 1));
            md = ($urandom_range(0, 7) == 0) ? 1 : 0;
            er = ($urandom_range(0, 9) == 0);
            step(rq, rw, KEY_W'($urandom_range(0, 11)), VAL_W'($urandom), md, 1'b0, '0, er);
        end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, '0, '0, 0, 1'b0, '0, 1'b1);
        idle(3);
        n_checks++;
        if (obs_fp !== 16'hFFFF) $display("FAIL sat_false_pos got %h want ffff", obs_fp);
        else n_pass++;
        n_checks++;
        if (obs_fn !== 16'h0000) $display("FAIL sat_false_neg got %h want 0000", obs_fn);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_evict();
        test_write_read();
        test_absent_read();
        test_back_to_back();
        test_err_window();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
